// File: rtl/lc3_data_mem_if.sv
// Load/store request bus between the LC3 pipeline controller and the data memory.
interface lc3_data_mem_if;
    logic [1:0]  mem_state;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic        busy;

    modport master (
        output mem_state, Data_addr, Data_din,
        input  Data_dout, complete_data, busy
    );

    modport slave (
        input  mem_state, Data_addr, Data_din,
        output Data_dout, complete_data, busy
    );
endinterface

// File: rtl/lc3_data_mem.sv
// LC3 data-memory responder: captures one load/store request and completes it
// with a single-cycle complete_data pulse after LATENCY cycles.
module lc3_data_mem #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    lc3_data_mem_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       din_q;
    logic              wr_q;
    logic [15:0]       dout_q;
    logic              accept;
    logic              do_access;
    logic [15:0]       mem [DEPTH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_state != 2'd3) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // The access itself happens on the edge that enters DONE.
                    state_nxt = DONE;
                    do_access = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            din_q  <= '0;
            wr_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q <= bus.Data_addr[ADDR_W-1:0];
                din_q  <= bus.Data_din;
                wr_q   <= (bus.mem_state == 2'd2);
            end
            if (do_access && !wr_q) begin
                dout_q <= mem[addr_q];
            end
        end
    end

    // Array is not reset; a reset keeps the FSM in IDLE so no write can slip through.
    always_ff @(posedge clk) begin
        if (do_access && wr_q) begin
            mem[addr_q] <= din_q;
        end
    end

    assign bus.Data_dout     = dout_q;
    assign bus.complete_data = (state == DONE);
    assign bus.busy          = (state != IDLE);

endmodule

// File: doc/lc3_data_mem.md
# lc3_data_mem

Data-memory responder for the LC3 pipeline: it serves the load/store accesses the pipeline controller requests through `mem_state` and answers each one with a single-cycle `complete_data` pulse after a fixed, parameterised latency. It sits between the execute/memory stage and the data-side storage, holding its own word array. It supports plain reads (LD/LDR), the two-step indirect sequence (LDI/STI) and writes (ST/STR/STI).

## Interface
Parameters:
- `ADDR_W`, default 8 — number of address bits used to index the word array (2^ADDR_W words of 16 bits).
- `LATENCY`, default 2 — number of cycles from request acceptance to `complete_data`; legal range 1..15.

Ports:
- `clk`  input  1 — single clock; every state element updates on the rising edge.
- `rst`  input  1 — reset, asynchronous, active-low.
- `mem_state`  input  2 — access request: 0 = read, 1 = indirect pointer read, 2 = write, 3 = idle/no request.
- `Data_addr`  input  16 — word address; only `[ADDR_W-1:0]` is used, upper bits are ignored.
- `Data_din`  input  16 — write data, used only when `mem_state` = 2.
- `Data_dout`  output  16 — registered read data.
- `complete_data`  output  1 — one-cycle pulse marking the end of the access.
- `busy`  output  1 — high while an access is in flight (WAIT or DONE state).

## Operation
- FSM states:
  - IDLE — waiting for a request.
  - WAIT — latency countdown.
  - DONE — completion cycle.
- IDLE behaviour:
  - `mem_state` != 3 at a rising edge → accept the request.
  - On acceptance, capture `Data_addr[ADDR_W-1:0]`, `Data_din` and the access type (read for codes 0 and 1, write for code 2).
  - Load `cnt` with `LATENCY-1` and go to WAIT.
  - `mem_state` = 3 → stay in IDLE.
- WAIT behaviour:
  - `cnt` != 0 → decrement `cnt`.
  - `cnt` = 0 → go to DONE.
  - On the edge entering DONE, perform the access using the captured values only:
    - Write: `mem[addr] <= din`.
    - Read: `Data_dout <= mem[addr]`.
- DONE behaviour:
  - `complete_data` = 1 for exactly this one cycle.
  - Always returns to IDLE at the next edge.
  - The responder does not accept a request in DONE, so there is at least one IDLE cycle between accesses.
- Input changes while in WAIT or DONE are ignored; the captured request completes unchanged.
- `mem_state` held at a request code after DONE is treated as a new request. This is how the controller issues back-to-back accesses and the second half of LDI/STI.
- `Data_dout` holds its value until the next read completes; writes do not change it.
- `busy` = (state != IDLE); it is combinational from the state register.
- `cnt` is 4 bits wide and never wraps, because `LATENCY` ≤ 15.

## Timing
- Reset values: FSM = IDLE, `cnt` = 0, `Data_dout` = 16'h0000, `complete_data` = 0, `busy` = 0.
- Array contents are not reset.
- Accepting a request at edge k gives:
  - `complete_data` high from edge k+LATENCY to edge k+LATENCY+1;
  - read data valid on `Data_dout` from edge k+LATENCY onward;
  - a write visible to any read accepted at edge k+LATENCY+1 or later.
- Minimum request period: LATENCY+2 cycles.
- Reset asserted mid-access (WAIT or DONE) aborts the access immediately:
  - no write occurs if the DONE edge has not been reached;
  - there is no `complete_data` pulse;
  - the FSM is in IDLE on reset release.
- Reset released while `mem_state` != 3 → the request is accepted at the first rising edge after release.
- `complete_data` is a registered state decode; there is no combinational path from any input to `complete_data` or `Data_dout`.

## Test plan
- **Reset values:** hold `rst` = 0 for 3 cycles with `mem_state` = 0 → `complete_data` = 0, `busy` = 0, `Data_dout` = 0x0000 throughout; release → accept on the first edge.
- **Write then read (LATENCY = 2):** `mem_state` = 2, `Data_addr` = 0x3005, `Data_din` = 0xBEEF accepted at edge k → `complete_data` pulse at k+2 only. Then `mem_state` = 0, address 0x3005 → `Data_dout` = 0xBEEF at that access's DONE edge.
- **Indirect sequence:** preload mem[0x10] = 0x0020 and mem[0x20] = 0x1234.
  - `mem_state` = 1, address 0x10 → `Data_dout` = 0x0020 with a pulse.
  - Then `mem_state` = 0, address 0x20 → 0x1234.
  - The two pulses are at least LATENCY+2 cycles apart.
- **Held request (LATENCY = 1):** keep `mem_state` = 0 constant for 12 cycles → `complete_data` pulses every 3 cycles, never on two consecutive cycles.
- **Reset mid-write:** start a write of 0xAAAA to mem[0x05] (which holds 0x5555); drop `rst` during WAIT → no pulse, mem[0x05] still reads 0x5555 afterwards.
- **Input change and aliasing (ADDR_W = 8):** accept a write of 0x1111 to 0x0105; change `Data_addr`/`Data_din` during WAIT → a read of 0x0005 returns 0x1111.
